// File: rtl/gpk_pkg.sv
// gpk_pkg: shared types and helpers for the gpk prefix adder.
// Exports gpk_t (K/P/G), gpk_combine and clog2.
package gpk_pkg;

  typedef enum logic [1:0] {
    K = 2'b00,
    P = 2'b01,
    G = 2'b11
  } gpk_t;

  // cur o prev: a generating or killing position wins,
  // a propagating one defers to the lower group.
  function automatic gpk_t gpk_combine(gpk_t cur, gpk_t prev);
    return (cur == P) ? prev : cur;
  endfunction

  function automatic int clog2(int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/gpk_prefix_stage.sv
// gpk_prefix_stage: NLEV prefix levels from FIRST_DIST, then a register.
// Ports: clk, rst, en_i, valid_i, g_i, p_i -> valid_o, g_o, p_o.
module gpk_prefix_stage
  import gpk_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FIRST_DIST = 1,
  parameter int NLEV       = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic [2*WIDTH+1:0]     g_i,
  input  logic [WIDTH-1:0]       p_i,
  output logic                   valid_o,
  output logic [2*WIDTH+1:0]     g_o,
  output logic [WIDTH-1:0]       p_o
);

  // Position 0 is the virtual carry-in slot, position j is bit j-1.
  gpk_t [WIDTH:0] lv0;

  for (genvar j = 0; j <= WIDTH; j++) begin : g_unpk
    assign lv0[j] = gpk_t'(g_i[2*j +: 2]);
  end

  for (genvar l = 0; l < NLEV; l++) begin : g_lv
    localparam int D = FIRST_DIST << l;
    gpk_t [WIDTH:0] prv;
    gpk_t [WIDTH:0] nxt;
    if (l == 0) begin : g_first
      assign prv = lv0;
    end else begin : g_next
      assign prv = g_lv[l-1].nxt;
    end
    for (genvar j = 0; j <= WIDTH; j++) begin : g_pos
      if (j >= D) begin : g_cmb
        assign nxt[j] = gpk_combine(prv[j], prv[j-D]);
      end else begin : g_pas
        assign nxt[j] = prv[j];
      end
    end
  end

  logic [2*WIDTH+1:0] g_d;
  logic [2*WIDTH+1:0] g_q;
  logic [WIDTH-1:0]   p_q;
  logic               valid_q;

  assign g_d = g_lv[NLEV-1].nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      g_q     <= '0;
      p_q     <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      g_q     <= g_d;
      p_q     <= p_i;
    end
  end

  assign valid_o = valid_q;
  assign g_o     = g_q;
  assign p_o     = p_q;

endmodule

// File: rtl/gpk_prefix_adder_pipe.sv
// gpk_prefix_adder_pipe: pipelined gpk prefix adder, cin/sub, valid/ready.
// Ports: clk, rst, in_valid/in_ready/in_x/in_y/in_cin/in_sub -> out_valid/out_ready/out_sum/out_cout/out_ovf.
module gpk_prefix_adder_pipe
  import gpk_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int STAGE_LEVELS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int NSTG   = (LEVELS + STAGE_LEVELS - 1) / STAGE_LEVELS;
  localparam int GW     = 2 * (WIDTH + 1);

  logic adv;

  logic [WIDTH-1:0] ye;
  logic [WIDTH-1:0] p0;
  logic             cin_e;
  logic [GW-1:0]    g0;

  always_comb begin
    ye    = in_sub ? ~in_y : in_y;
    cin_e = in_sub | in_cin;
    p0    = in_x ^ ye;
    g0    = '0;
    g0[1:0] = cin_e ? G : K;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (1'b1)
        in_x[i] & ye[i]: g0[2*i+2 +: 2] = G;
        p0[i]:           g0[2*i+2 +: 2] = P;
        default:         g0[2*i+2 +: 2] = K;
      endcase
    end
  end

  logic             v_ch [NSTG+1];
  logic [GW-1:0]    g_ch [NSTG+1];
  logic [WIDTH-1:0] p_ch [NSTG+1];

  assign v_ch[0] = in_valid;
  assign g_ch[0] = g0;
  assign p_ch[0] = p0;

  for (genvar s = 0; s < NSTG; s++) begin : g_stg
    localparam int REM = LEVELS - s * STAGE_LEVELS;
    localparam int NL  = (REM < STAGE_LEVELS) ? REM : STAGE_LEVELS;
    gpk_prefix_stage #(
      .WIDTH      (WIDTH),
      .FIRST_DIST (1 << (s * STAGE_LEVELS)),
      .NLEV       (NL)
    ) u_stg (
      .clk     (clk),
      .rst     (rst),
      .en_i    (adv),
      .valid_i (v_ch[s]),
      .g_i     (g_ch[s]),
      .p_i     (p_ch[s]),
      .valid_o (v_ch[s+1]),
      .g_o     (g_ch[s+1]),
      .p_o     (p_ch[s+1])
    );
  end

  // When WIDTH is a power of two the top position can still be P
  // after LEVELS levels: every bit below it propagates, so it takes cin.
  logic [WIDTH:0]   cy;
  logic             cin_f;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  always_comb begin
    cin_f = (g_ch[NSTG][1:0] == G);
    cy    = '0;
    for (int j = 0; j <= WIDTH; j++) begin
      cy[j] = (g_ch[NSTG][2*j +: 2] == G)
            | ((g_ch[NSTG][2*j +: 2] == P) & cin_f);
    end
    sum_d  = p_ch[NSTG] ^ cy[WIDTH-1:0];
    cout_d = cy[WIDTH];
    ovf_d  = cy[WIDTH] ^ cy[WIDTH-1];
  end

  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= v_ch[NSTG];
      out_sum_q   <= sum_d;
      out_cout_q  <= cout_d;
      out_ovf_q   <= ovf_d;
    end
  end

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule
